// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. An operation is issued with
//   a one-cycle start in IDLE. It runs one bit per cycle, either radix-2
//   shift-add multiply or restoring divide, on operand magnitudes. It ends with a
//   one-cycle done strobe that drives the register-file write port.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   start      issue request, sampled only in IDLE
//   funct3     RV32M op select (MUL..REMU)
//   operand_a  rs1 value
//   operand_b  rs2 value
//   rd_in      destination register, captured at issue
//   flush      synchronous abort; wins over start and suppresses done
//   busy       high whenever the unit is not IDLE
//   done       one-cycle result-valid / write-enable strobe
//   result     result; holds the last written value between operations
//   rd_out     destination register of the current / last operation
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rd_out
);

    localparam int DW    = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]    ZERO_W   = {DW{1'b0}};
    localparam logic [DW-1:0]    ONES_W   = {DW{1'b1}};
    localparam logic [DW-1:0]    MIN_W    = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Conditional two's-complement negate, single width
    function automatic logic [DW-1:0] neg_w(input logic [DW-1:0] v, input logic en);
        logic [DW-1:0] r;
        if (en) begin
            r = ~v + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negate, double width (full product)
    function automatic logic [2*DW-1:0] neg_dw(input logic [2*DW-1:0] v, input logic en);
        logic [2*DW-1:0] r;
        if (en) begin
            r = ~v + {{(2*DW-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           r_funct3;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                 r_neg;
    logic                 r_fast;
    logic [CNT_W-1:0]     r_count;
    logic [2*DW-1:0]      r_acc;       // {partial product | remainder, multiplier | quotient}
    logic [DW-1:0]        r_op;        // multiplicand (MUL) or divisor (DIV) magnitude
    logic [DW-1:0]        r_res_pend;  // result presented during DONE
    logic [DW-1:0]        r_result;    // last committed result

    logic                 w_signed_a;
    logic                 w_signed_b;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [DW-1:0]        w_mag_a;
    logic [DW-1:0]        w_mag_b;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic                 w_fast;
    logic [DW-1:0]        w_fast_res;
    logic                 w_neg_start;

    logic [DW:0]          w_mul_sum;
    logic [2*DW-1:0]      w_mul_next;
    logic [DW:0]          w_div_shift;
    logic [DW-1:0]        w_div_diff;
    logic                 w_div_ge;
    logic [2*DW-1:0]      w_div_next;
    logic [2*DW-1:0]      w_prod_fix;
    logic [DW-1:0]        w_quo_fix;
    logic [DW-1:0]        w_rem_fix;
    logic [DW-1:0]        w_iter_res;

    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic                 w_commit;
    logic                 w_done;

    // Operand signedness per RV32M op
    always_comb begin
        w_signed_a = 1'b0;
        w_signed_b = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_signed_a = 1'b1;
                w_signed_b = 1'b1;
            end
            3'b010: begin
                w_signed_a = 1'b1;
                w_signed_b = 1'b0;
            end
            default: begin
                w_signed_a = 1'b0;
                w_signed_b = 1'b0;
            end
        endcase
    end

    assign w_sign_a   = w_signed_a & operand_a[DW-1];
    assign w_sign_b   = w_signed_b & operand_b[DW-1];
    assign w_mag_a    = neg_w(operand_a, w_sign_a);
    assign w_mag_b    = neg_w(operand_b, w_sign_b);
    assign w_div_zero = (operand_b == ZERO_W);
    assign w_ovf      = w_signed_a & funct3[2] & (operand_a == MIN_W) & (operand_b == ONES_W);
    assign w_fast     = funct3[2] & (w_div_zero | w_ovf);
    // Remainder takes the dividend's sign; everything else takes sign(a) ^ sign(b)
    assign w_neg_start = (funct3[2] & funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);

    // Fixed results for divide-by-zero and signed overflow
    always_comb begin
        w_fast_res = ZERO_W;
        if (w_div_zero) begin
            w_fast_res = funct3[1] ? operand_a : ONES_W;
        end else begin
            w_fast_res = funct3[1] ? ZERO_W : MIN_W;
        end
    end

    // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set
    assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + {1'b0, (r_acc[0] ? r_op : ZERO_W)};
    assign w_mul_next = {w_mul_sum, r_acc[DW-1:1]};

    // Restoring divide step; a successful subtract always fits in DW bits
    assign w_div_shift = {r_acc[2*DW-1:DW], r_acc[DW-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_op});
    assign w_div_diff  = w_div_shift[DW-1:0] - r_op;
    assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[DW-1:0]), r_acc[DW-2:0], w_div_ge};

    // The final iteration's value is sign-fixed and selected in the same cycle
    assign w_prod_fix = neg_dw(w_mul_next, r_neg);
    assign w_quo_fix  = neg_w(w_div_next[DW-1:0], r_neg);
    assign w_rem_fix  = neg_w(w_div_next[2*DW-1:DW], r_neg);

    // Result select for the iterative path
    always_comb begin
        w_iter_res = ZERO_W;
        case (r_funct3)
            3'b000:                 w_iter_res = w_prod_fix[DW-1:0];
            3'b001, 3'b010, 3'b011: w_iter_res = w_prod_fix[2*DW-1:DW];
            3'b100, 3'b101:         w_iter_res = w_quo_fix;
            3'b110, 3'b111:         w_iter_res = w_rem_fix;
            default:                w_iter_res = ZERO_W;
        endcase
    end

    // A fast-path op spends exactly one cycle in DIV so its done lands one
    // cycle after the issue edge.
    assign w_last = r_fast | (r_count == LAST_CNT);

    // Next-state and control strobes
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_commit     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (start) begin
                    w_load       = 1'b1;
                    w_next_state = (w_fast | funct3[2]) ? S_DIV : S_MUL;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_step       = 1'b1;
                    w_next_state = w_last ? S_DONE : r_state;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                if (flush) begin
                    w_done   = 1'b0;
                    w_commit = 1'b0;
                end else begin
                    w_done   = 1'b1;
                    w_commit = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: operand capture, iteration, result commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_funct3   <= 3'b000;
            r_rd       <= {ADDR_WIDTH{1'b0}};
            r_neg      <= 1'b0;
            r_fast     <= 1'b0;
            r_count    <= {CNT_W{1'b0}};
            r_acc      <= {(2*DW){1'b0}};
            r_op       <= ZERO_W;
            r_res_pend <= ZERO_W;
            r_result   <= ZERO_W;
        end else if (w_load) begin
            r_funct3   <= funct3;
            r_rd       <= rd_in;
            r_neg      <= w_neg_start;
            r_fast     <= w_fast;
            r_count    <= {CNT_W{1'b0}};
            r_acc      <= {ZERO_W, (funct3[2] ? w_mag_a : w_mag_b)};
            r_op       <= funct3[2] ? w_mag_b : w_mag_a;
            r_res_pend <= w_fast_res;
        end else if (w_step) begin
            r_acc   <= (r_state == S_DIV) ? w_div_next : w_mul_next;
            r_count <= r_count + ONE_CNT;
            if (w_last && !r_fast) begin
                r_res_pend <= w_iter_res;
            end
        end else if (w_commit) begin
            r_result <= r_res_pend;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = w_done;
    // During DONE the new value is shown; it only becomes the held value if
    // the DONE cycle is not flushed.
    assign result = (r_state == S_DONE) ? r_res_pend : r_result;
    assign rd_out = r_rd;

endmodule
